dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the single-port, word-organised data RAM (256-byte address space, 64 words, combinational read, clocked write). It shares the RAM between two requesters, port 0 (CPU load/store unit) and port 1 (DMA/debug master), using round-robin arbitration. It turns byte, halfword and word accesses into a registered read followed, for stores, by a read-modify-write word write. It also returns load data aligned and sign- or zero-extended.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_lane_unit.sv | 72 +++++++
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter and its lane unit.
package dmem_pkg;

    localparam int DMEM_NPORTS = 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    // True when the access cannot be served from a single aligned word.
    function automatic logic misaligned(input size_e size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane datapath: merges store data into the read word and extracts
// aligned, sign/zero-extended load data from it.
module dmem_lane_unit
    import dmem_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] i_rd_q,
    input  logic [DW-1:0] i_wdata,
    input  logic [1:0]    i_addr_lo,
    input  size_e         i_size,
    input  logic          i_sext,
    output logic [DW-1:0] o_merged,
    output logic [DW-1:0] o_load
);

    localparam int NB = DW / 8;

    logic [NB-1:0] w_be;
    logic [DW-1:0] w_wrep;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    // Replicate the store data across every lane so the byte enables alone pick the target.
    always_comb begin
        w_be   = '0;
        w_wrep = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                w_wrep = {NB{i_wdata[7:0]}};
                w_be   = NB'(1) << i_addr_lo;
            end
            SZ_HALF: begin
                w_wrep = {(NB/2){i_wdata[15:0]}};
                w_be   = i_addr_lo[1] ? NB'(4'b1100) : NB'(4'b0011);
            end
            SZ_WORD: begin
                w_wrep = i_wdata;
                w_be   = '1;
            end
            default: begin
                w_wrep = i_wdata;
                w_be   = '0;
            end
        endcase
    end

    always_comb begin
        o_merged = i_rd_q;
        for (int b = 0; b < NB; b++) begin
            if (w_be[b]) o_merged[8*b +: 8] = w_wrep[8*b +: 8];
        end
    end

    always_comb begin
        w_byte = 8'h00;
        for (int b = 0; b < NB; b++) begin
            if (i_addr_lo == 2'(b)) w_byte = i_rd_q[8*b +: 8];
        end
        w_half = i_addr_lo[1] ? i_rd_q[16 +: 16] : i_rd_q[0 +: 16];
    end

    always_comb begin
        case (i_size)
            SZ_BYTE: o_load = {{(DW-8){i_sext & w_byte[7]}}, w_byte};
            SZ_HALF: o_load = {{(DW-16){i_sext & w_half[15]}}, w_half};
            SZ_WORD: o_load = i_rd_q;
            default: o_load = '0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and read / read-modify-write sequencer
// in front of a single-port word RAM with combinational read.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [1:0]    m0_size,
    input  logic          m0_sext,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [1:0]    m1_size,
    input  logic          m1_sext,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,

    output logic          mem_ce,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int NP = DMEM_NPORTS;

    logic [NP-1:0]         w_req;
    logic [NP-1:0]         w_we;
    logic [NP-1:0][AW-1:0] w_addr;
    logic [NP-1:0][1:0]    w_size;
    logic [NP-1:0]         w_sext;
    logic [NP-1:0][DW-1:0] w_wdata;
    logic [NP-1:0]         w_gnt;
    logic [NP-1:0]         w_rvalid;
    logic [NP-1:0]         w_err;
    logic [NP-1:0][DW-1:0] w_rdata;

    assign w_req   = {m1_req,   m0_req};
    assign w_we    = {m1_we,    m0_we};
    assign w_addr  = {m1_addr,  m0_addr};
    assign w_size  = {m1_size,  m0_size};
    assign w_sext  = {m1_sext,  m0_sext};
    assign w_wdata = {m1_wdata, m0_wdata};

    state_e        r_state;
    logic          r_last;
    logic          r_port;
    logic          r_we;
    logic          r_sext;
    logic          r_err;
    logic [AW-1:0] r_addr;
    size_e         r_size;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rd_q;

    logic          w_sel;
    logic          w_take;
    logic          w_misal;
    size_e         w_sel_size;
    logic          w_mem_act;
    logic          w_resp;
    logic [DW-1:0] w_merged;
    logic [DW-1:0] w_load;

    // On a tie the port that was not served last wins; a lone request always wins.
    assign w_sel      = (w_req[0] & w_req[1]) ? ~r_last : w_req[1];
    assign w_take     = reset_n && (r_state == ST_IDLE) && (|w_req);
    assign w_sel_size = size_e'(w_size[w_sel]);
    assign w_misal    = misaligned(w_sel_size, w_addr[w_sel][1:0]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_sext  <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_size  <= SZ_BYTE;
            r_wdata <= '0;
            r_rd_q  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_last  <= w_sel;
                        r_port  <= w_sel;
                        r_we    <= w_we[w_sel];
                        r_sext  <= w_sext[w_sel];
                        r_addr  <= w_addr[w_sel];
                        r_size  <= w_sel_size;
                        r_wdata <= w_wdata[w_sel];
                        r_err   <= w_misal;
                        r_state <= w_misal ? ST_RESP : ST_READ;
                    end
                end
                ST_READ: begin
                    r_rd_q  <= mem_rdata;
                    r_state <= r_we ? ST_WRITE : ST_RESP;
                end
                ST_WRITE: r_state <= ST_RESP;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    dmem_lane_unit #(.DW(DW)) u_lane (
        .i_rd_q    (r_rd_q),
        .i_wdata   (r_wdata),
        .i_addr_lo (r_addr[1:0]),
        .i_size    (r_size),
        .i_sext    (r_sext),
        .o_merged  (w_merged),
        .o_load    (w_load)
    );

    assign w_mem_act = (r_state == ST_READ) || (r_state == ST_WRITE);
    assign mem_ce    = w_mem_act;
    assign mem_wr_en = (r_state == ST_WRITE);
    assign mem_addr  = w_mem_act ? {r_addr[AW-1:2], 2'b00} : '0;
    assign mem_wdata = (r_state == ST_WRITE) ? w_merged : '0;
    assign w_resp    = (r_state == ST_RESP);

    for (genvar p = 0; p < NP; p++) begin : g_port
        assign w_gnt[p]    = w_take && (w_sel == 1'(p));
        assign w_rvalid[p] = w_resp && (r_port == 1'(p));
        assign w_err[p]    = w_rvalid[p] && r_err;
        assign w_rdata[p]  = (w_rvalid[p] && !r_err && !r_we) ? w_load : '0;
    end

    assign m0_gnt    = w_gnt[0];
    assign m0_rvalid = w_rvalid[0];
    assign m0_err    = w_err[0];
    assign m0_rdata  = w_rdata[0];
    assign m1_gnt    = w_gnt[1];
    assign m1_rvalid = w_rvalid[1];
    assign m1_err    = w_err[1];
    assign m1_rdata  = w_rdata[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table plus arbitration and reset sequences.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_req = 0, m0_we = 0, m0_sext = 0;
    logic [7:0]  m0_addr = 0;
    logic [1:0]  m0_size = 0;
    logic [31:0] m0_wdata = 0;
    logic        m1_req = 0, m1_we = 0, m1_sext = 0;
    logic [7:0]  m1_addr = 0;
    logic [1:0]  m1_size = 0;
    logic [31:0] m1_wdata = 0;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_ce, mem_wr_en;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(8), .DW(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_size(m0_size),
        .m0_sext(m0_sext), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_size(m1_size),
        .m1_sext(m1_sext), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_ce(mem_ce), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // RAM model: combinational read, clocked write, one-cycle preload.
    logic [31:0] ram [0:63];
    logic        ram_load = 1'b1;
    assign mem_rdata = ram[mem_addr[7:2]];
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'(100 + i);
            ram[62] <= 32'h87654321;
            ram[63] <= 32'hF0F0F0F0;
        end else if (mem_ce && mem_wr_en) begin
            ram[mem_addr[7:2]] <= mem_wdata;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit p, input bit req, input bit we, input logic [7:0] addr,
                         input logic [1:0] size, input bit sext, input logic [31:0] wdata);
        m0_req = 0; m1_req = 0;
        if (!p) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_size = size; m0_sext = sext; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_size = size; m1_sext = sext; m1_wdata = wdata;
        end
    endtask

    function automatic logic any_out();
        return |{m0_gnt, m0_rvalid, m0_err, m0_rdata, m1_gnt, m1_rvalid, m1_err, m1_rdata,
                 mem_ce, mem_wr_en, mem_addr, mem_wdata};
    endfunction

    task automatic do_reset();
        reset_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic wait_rv(input bit p, output bit got, output int lat, output logic [31:0] rd,
                           output logic er, output bit ce_seen, output bit wr_seen,
                           output logic [31:0] wd);
        got = 0; lat = 0; rd = 0; er = 0; ce_seen = 0; wr_seen = 0; wd = 0;
        for (int k = 1; k <= 10 && !got; k++) begin
            @(negedge clk);
            if (mem_ce) ce_seen = 1;
            if (mem_wr_en) begin wr_seen = 1; wd = mem_wdata; end
            if (p ? m1_rvalid : m0_rvalid) begin
                got = 1; lat = k;
                rd = p ? m1_rdata : m0_rdata;
                er = p ? m1_err : m0_err;
                chk("other_rvalid", p ? m0_rvalid : m1_rvalid, 0);
            end
        end
        if (!got) chk("rvalid_timeout", 0, 1);
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [7:0]  addr;
        logic [1:0]  size;
        bit          sext;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
        logic [31:0] exp_wd;
    } vec_t;

    task automatic run_vec(input vec_t v);
        bit got, ce_seen, wr_seen;
        int wait_c, lat;
        logic [31:0] rd, wd;
        logic er;
        @(posedge clk); #1;
        drive(v.port, 1, v.we, v.addr, v.size, v.sext, v.wdata);
        got = 0; wait_c = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (v.port ? m1_gnt : m0_gnt) got = 1;
            else begin wait_c++; @(posedge clk); #1; end
        end
        if (!got) begin
            chk("gnt_timeout", 0, 1);
            drive(v.port, 0, 0, 0, 0, 0, 0);
            return;
        end
        chk("gnt_same_cycle", wait_c, 0);
        @(posedge clk); #1;
        drive(v.port, 0, 0, 0, 0, 0, 0);
        wait_rv(v.port, got, lat, rd, er, ce_seen, wr_seen, wd);
        if (got) begin
            chk("rdata", rd, v.exp_rd);
            chk("err", er, v.exp_err);
            chk("latency", lat, v.exp_err ? 1 : (v.we ? 3 : 2));
            chk("mem_ce_used", ce_seen, !v.exp_err);
            chk("write_done", wr_seen, v.we && !v.exp_err);
            if (v.we && !v.exp_err) chk("merged_wdata", wd, v.exp_wd);
        end
    endtask

    vec_t tbl[15];

    initial begin
        bit got, ce_seen, wr_seen;
        int lat;
        logic [31:0] rd, wd;
        logic er;

        tbl[0]  = '{0, 0, 8'hFB, 2'b00, 1, 32'h0,        32'hFFFFFF87, 0, 32'h0};
        tbl[1]  = '{0, 0, 8'hFB, 2'b00, 0, 32'h0,        32'h00000087, 0, 32'h0};
        tbl[2]  = '{1, 0, 8'hF8, 2'b01, 1, 32'h0,        32'h00004321, 0, 32'h0};
        tbl[3]  = '{1, 0, 8'hFA, 2'b01, 1, 32'h0,        32'hFFFF8765, 0, 32'h0};
        tbl[4]  = '{0, 1, 8'hF9, 2'b00, 0, 32'h000000AA, 32'h0,        0, 32'h8765AA21};
        tbl[5]  = '{0, 0, 8'hF8, 2'b10, 0, 32'h0,        32'h8765AA21, 0, 32'h0};
        tbl[6]  = '{1, 0, 8'h02, 2'b10, 0, 32'h0,        32'h0,        1, 32'h0};
        tbl[7]  = '{0, 1, 8'h05, 2'b01, 0, 32'h0000BEEF, 32'h0,        1, 32'h0};
        tbl[8]  = '{1, 1, 8'hFE, 2'b01, 0, 32'h1234BEEF, 32'h0,        0, 32'hBEEFF0F0};
        tbl[9]  = '{1, 0, 8'hFC, 2'b10, 0, 32'h0,        32'hBEEFF0F0, 0, 32'h0};
        tbl[10] = '{0, 0, 8'h04, 2'b00, 1, 32'h0,        32'h00000065, 0, 32'h0};
        tbl[11] = '{0, 0, 8'h08, 2'b11, 0, 32'h0,        32'h0,        1, 32'h0};
        tbl[12] = '{1, 0, 8'hFE, 2'b01, 0, 32'h0,        32'h0000BEEF, 0, 32'h0};
        tbl[13] = '{0, 1, 8'h20, 2'b10, 0, 32'hDEADBEEF, 32'h0,        0, 32'hDEADBEEF};
        tbl[14] = '{0, 0, 8'h23, 2'b00, 1, 32'h0,        32'hFFFFFFDE, 0, 32'h0};

        // Reset state, including a request held while in reset.
        m0_req = 1;
        @(posedge clk); #1;
        ram_load = 0;
        @(negedge clk);
        chk("reset_outputs", any_out(), 0);
        chk("reset_no_gnt", m0_gnt, 0);
        m0_req = 0;
        @(negedge clk);
        reset_n = 1;

        foreach (tbl[i]) run_vec(tbl[i]);

        // Simultaneous requests from reset: port 0, then port 1, then port 0 again.
        do_reset();
        @(posedge clk); #1;
        m0_req = 1; m0_we = 0; m0_addr = 8'h00; m0_size = 2'b10; m0_sext = 0;
        m1_req = 1; m1_we = 0; m1_addr = 8'h04; m1_size = 2'b10; m1_sext = 0;
        @(negedge clk);
        chk("tie1_m0_gnt", m0_gnt, 1);
        chk("tie1_m1_gnt", m1_gnt, 0);
        @(posedge clk); #1; m0_req = 0;
        wait_rv(0, got, lat, rd, er, ce_seen, wr_seen, wd);
        chk("tie1_rdata", rd, 32'd100);
        chk("tie1_latency", lat, 2);
        @(negedge clk);
        chk("tie2_m1_gnt", m1_gnt, 1);
        @(posedge clk); #1; m1_req = 0;
        wait_rv(1, got, lat, rd, er, ce_seen, wr_seen, wd);
        chk("tie2_rdata", rd, 32'd101);
        @(posedge clk); #1;
        m0_req = 1; m1_req = 1;
        @(negedge clk);
        chk("tie3_m0_gnt", m0_gnt, 1);
        chk("tie3_m1_gnt", m1_gnt, 0);
        @(posedge clk); #1; m0_req = 0; m1_req = 0;
        wait_rv(0, got, lat, rd, er, ce_seen, wr_seen, wd);
        chk("tie3_rdata", rd, 32'd100);

        // Reset during the WRITE cycle of a store must suppress the write and the response.
        @(posedge clk); #1;
        drive(0, 1, 1, 8'h00, 2'b10, 0, 32'h12345678);
        @(negedge clk);
        chk("rstw_gnt", m0_gnt, 1);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("rstw_in_write", mem_wr_en, 1);
        chk("rstw_wdata", mem_wdata, 32'h12345678);
        #2 reset_n = 0;
        #1 chk("rstw_outputs_zero", any_out(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        got = 0;
        repeat (4) begin
            @(negedge clk);
            if (m0_rvalid || m1_rvalid) got = 1;
        end
        chk("rstw_no_rvalid", got, 0);
        run_vec('{0, 0, 8'h00, 2'b10, 0, 32'h0, 32'd100, 0, 32'h0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
